// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one round per clock, round keys derived on the fly
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   start      - begin one decryption (accepted in IDLE or DONE)
//   ciphertext - 128-bit block, byte 0 in [127:120], sampled on the accepting edge
//   key        - 128-bit cipher key K0, sampled on the accepting edge
//   plaintext  - registered result, valid while done=1
//   done       - high while plaintext holds a completed result
//   busy       - high during key expansion and decryption
module aes_inv_cipher (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} fsm_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^k), k=1..7; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < 10; i++) if (i < int'(r)) c = xt(c);
    return c;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] kfwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ subrot(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one schedule step: trailing words first, since the leading word needs the recovered w3.
  function automatic logic [127:0] kinv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ subrot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte (r,c) lives at index 4c+r; InvShiftRows moves row r right by r columns.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] dec_sb;
  logic [7:0]   rc;

  always_comb begin
    dec_sb = inv_sr_sb(state_q);
    rc = rcon(rnd_q);
    fsm_d = fsm_q;
    state_d = state_q;
    rk_d = rk_q;
    pt_d = pt_q;
    rnd_d = rnd_q;
    done_d = done_q;
    busy_d = busy_q;
    case (fsm_q)
      KEXP: begin
        rk_d = kfwd(rk_q, rc);
        rnd_d = rnd_q == 4'd10 ? 4'd10 : rnd_q + 4'd1;
        fsm_d = rnd_q == 4'd10 ? DEC : KEXP;
      end
      DEC: begin
        state_d = rnd_q == 4'd10 ? state_q ^ rk_q :
                  rnd_q == 4'd0  ? dec_sb ^ rk_q : inv_mix(dec_sb ^ rk_q);
        if (rnd_q != 4'd0) begin
          rk_d = kinv(rk_q, rc);
          rnd_d = rnd_q - 4'd1;
        end else begin
          pt_d = state_d;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d = DONE;
        end
      end
      default: begin
        if (start) begin
          fsm_d = KEXP;
          state_d = ciphertext;
          rk_d = key;
          rnd_d = 4'd1;
          done_d = 1'b0;
          busy_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= IDLE;
      state_q <= '0;
      rk_q <= '0;
      pt_q <= '0;
      rnd_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      rk_q <= rk_d;
      pt_q <= pt_d;
      rnd_q <= rnd_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign plaintext = pt_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher: scoreboard bench for aes_inv_cipher using FIPS-197 vectors
module tb_aes_inv_cipher;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] JUNK = 128'hdeadbeef0123456789abcdeffeedface;

  aes_inv_cipher dut (
    .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(plaintext), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int acc;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p, input bit hold);
    start = 1'b1;
    ciphertext = c;
    key = k;
    acc = cyc + 1;
    sb.push_back('{p, acc});
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    logic dp;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dp) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got %h want none", plaintext);
        end else begin
          e = sb.pop_front();
          chk("plaintext", plaintext, e.pt);
          chk("latency", 128'(cyc - e.acc), 128'd21);
        end
      end
      dp = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_pt", plaintext, 128'd0);
    reset = 1'b0;

    issue(C1, K1, P1, 1'b0);
    chk("c1_busy", 128'(busy), 128'd1);
    chk("c1_done_low", 128'(done), 128'd0);
    to_cycle(acc + 10);
    chk("c1_rk_k10", dut.rk_q, K1_10);
    drain();
    chk("c1_rk_k0", dut.rk_q, K1);
    chk("c1_done", 128'(done), 128'd1);
    chk("c1_busy_low", 128'(busy), 128'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("c1_hold_done", 128'(done), 128'd1);
    chk("c1_hold_pt", plaintext, P1);

    issue(C2, K2, P2, 1'b0);
    to_cycle(acc + 5);
    start = 1'b1;
    ciphertext = JUNK;
    key = JUNK;
    @(posedge clk);
    #1;
    start = 1'b0;
    to_cycle(acc + 15);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    issue(C1, K1, P1, 1'b1);
    a1 = acc;
    to_cycle(a1 + 5);
    ciphertext = JUNK;
    key = JUNK;
    to_cycle(a1 + 21);
    ciphertext = C2;
    key = K2;
    acc = a1 + 22;
    sb.push_back('{P2, acc});
    to_cycle(a1 + 22);
    chk("b2b_done_width", 128'(done), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    to_cycle(a1 + 26);
    ciphertext = JUNK;
    key = ~JUNK;
    to_cycle(a1 + 30);
    start = 1'b0;
    drain();
    chk("b2b_final_done", 128'(done), 128'd1);

    issue(C1, K1, P1, 1'b0);
    to_cycle(acc + 14);
    reset = 1'b1;
    start = 1'b1;
    sb.delete();
    to_cycle(acc + 15);
    chk("rst_mid_done", 128'(done), 128'd0);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_pt", plaintext, 128'd0);
    chk("rst_mid_rk", dut.rk_q, 128'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_idle_busy", 128'(busy), 128'd0);
    issue(C1, K1, P1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
